// File: rtl/gen_stream_fifo.sv
// rtl/gen_stream_fifo.sv - elastic buffer carrying a two-lane generator stream plus end-of-stream
// Optional occupancy outputs _level/_max_level under GEN_STREAM_FIFO_LEVEL_EN.
module gen_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic             _in_valid,
  input  logic             _in_done,
  input  logic [WIDTH-1:0] _in_out_0,
  input  logic [WIDTH-1:0] _in_out_1,
  output logic             _in_ready,
  input  logic             _ready,
  output logic             _valid,
  output logic             _done,
  output logic [WIDTH-1:0] _out_0,
  output logic [WIDTH-1:0] _out_1
`ifdef GEN_STREAM_FIFO_LEVEL_EN
  ,
  output logic [AW:0]      _level,
  output logic [AW:0]      _max_level
`endif
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_0 [DEPTH];
  logic [WIDTH-1:0] mem_1 [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic             eos, eos_next;
  logic             done_q;
  logic             push, pop;

  assign _in_ready = (count != FULL_COUNT);
  assign _valid    = (count != '0);
  assign push      = _in_valid & _in_ready & ~_start;
  assign pop       = _valid & _ready;
  assign _out_0    = _valid ? mem_0[rd_ptr] : '0;
  assign _out_1    = _valid ? mem_1[rd_ptr] : '0;
  assign _done     = done_q;

  always_comb begin
    count_next = count;
    eos_next   = eos;
    if (_reset || _start) begin
      count_next = '0;
      eos_next   = 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
      if (_in_done) eos_next = 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge _clock) begin
    if (push) begin
      mem_0[wr_ptr] <= _in_out_0;
      mem_1[wr_ptr] <= _in_out_1;
    end
  end

  always_ff @(posedge _clock) begin
    if (_reset || _start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
    count  <= count_next;
    eos    <= eos_next;
    // Evaluated on next-state so _done rises right after the final pop edge.
    done_q <= eos_next & (count_next == '0);
  end

`ifdef GEN_STREAM_FIFO_LEVEL_EN
  logic [AW:0] max_q;

  always_ff @(posedge _clock) begin
    if (_reset || _start) begin
      max_q <= '0;
    end else if (count > max_q) begin
      max_q <= count;
    end
  end

  assign _level     = count;
  assign _max_level = max_q;
`endif

endmodule

// File: tb/tb_gen_stream_fifo.sv
// tb/tb_gen_stream_fifo.sv - directed and randomized-ready checks of gen_stream_fifo against a queue model
module tb_gen_stream_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset, start, in_valid, in_done, in_ready, ready, valid, done;
  logic [WIDTH-1:0] in_0, in_1, out_0, out_1;
`ifdef GEN_STREAM_FIFO_LEVEL_EN
  logic [AW:0]      level, max_level;
`endif

  gen_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    ._clock(clk), ._reset(reset), ._start(start),
    ._in_valid(in_valid), ._in_done(in_done), ._in_out_0(in_0), ._in_out_1(in_1),
    ._in_ready(in_ready), ._ready(ready), ._valid(valid), ._done(done),
    ._out_0(out_0), ._out_1(out_1)
`ifdef GEN_STREAM_FIFO_LEVEL_EN
    , ._level(level), ._max_level(max_level)
`endif
  );

  always #5 clk = ~clk;

  logic [63:0] q[$];
  bit          m_eos;
  int          m_max;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe();
    int n;
    n = q.size();
    check("valid", 64'(valid), 64'(n != 0));
    check("in_ready", 64'(in_ready), 64'(n < DEPTH));
    check("done", 64'(done), 64'(m_eos && n == 0));
    check("out", {out_0, out_1}, (n != 0) ? q[0] : 64'd0);
`ifdef GEN_STREAM_FIFO_LEVEL_EN
    check("level", 64'(level), 64'(n));
    check("max_level", 64'(max_level), 64'(m_max));
    check("max_le_depth", 64'(max_level <= DEPTH), 64'd1);
`endif
  endtask

  // Advances the model by one clock from the current inputs, then the DUT, then compares.
  task automatic tick();
    int n;
    bit m_pop, m_push;
    n = q.size();
    m_pop  = (n != 0) && ready;
    m_push = in_valid && (n < DEPTH) && !start;
    if (reset || start) begin
      q.delete();
      m_eos = 0;
      m_max = 0;
    end else begin
      if (n > m_max) m_max = n;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back({in_0, in_1});
      if (in_done) m_eos = 1;
    end
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic set_in(input bit v, input int a, input int b, input bit d);
    in_valid = v;
    in_0 = WIDTH'(a);
    in_1 = WIDTH'(b);
    in_done = d;
  endtask

  initial begin
    int idx, cyc;
    bit acc;
    reset = 1'b1; start = 1'b0; ready = 1'b1;
    set_in(0, 0, 0, 0);
    tick();
    reset = 1'b0;
    check("reset_out", {out_0, out_1}, 64'd0);

    // 1: four pushes with done on the last one, consumer always ready
    for (int k = 0; k < 4; k++) begin
      set_in(1, 3 * k + 1, k, k == 3);
      tick();
      check("t1_out", {out_0, out_1}, {32'(3 * k + 1), 32'(k)});
    end
    set_in(0, 0, 0, 0);
    tick();
    check("t1_done", 64'(done), 64'd1);
    tick();
    check("t1_done_idle", 64'(done), 64'd1);

    // 2: five offered into DEPTH=4 with the consumer stalled
    start = 1'b1; tick(); start = 1'b0;
    check("t2_start_done", 64'(done), 64'd0);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, i, -i, 0);
      tick();
    end
    check("t2_full", 64'(in_ready), 64'd0);
    set_in(1, 4, -4, 0);
    tick(); tick();
    check("t2_head_hold", {out_0, out_1}, 64'd0);
    ready = 1'b1;
    tick();
    check("t2_ready_back", 64'(in_ready), 64'd1);
    tick();
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    check("t2_drained", 64'(valid), 64'd0);

    // 3: three full fills, each relieved by one pop-only cycle then drained
    for (int f = 0; f < 3; f++) begin
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        set_in(1, 16 * f + i, f, 0);
        tick();
      end
      set_in(0, 0, 0, 0);
      ready = 1'b1;
      tick();
      check("t3_refill_ready", 64'(in_ready), 64'd1);
      check("t3_head", {out_0, out_1}, {32'(16 * f + 1), 32'(f)});
      for (int i = 0; i < 3; i++) tick();
    end

    // 4: done arrives with two entries buffered
    start = 1'b1; tick(); start = 1'b0;
    ready = 1'b0;
    set_in(1, 7, 8, 0); tick();
    set_in(1, 9, 10, 0); tick();
    set_in(0, 0, 0, 1); tick();
    in_done = 1'b0;
    check("t4_done_wait", 64'(done), 64'd0);
    ready = 1'b1;
    tick();
    check("t4_done_one_left", 64'(done), 64'd0);
    tick();
    check("t4_done_set", 64'(done), 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    check("t4_start_clears", 64'(done), 64'd0);

    // 5: start with three entries buffered, then a clean stream 0,2,4,6,8
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 100 + i, 1, 0);
      tick();
    end
    set_in(1, 55, 55, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_flush_valid", 64'(valid), 64'd0);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 2 * i, i, i == 4);
      tick();
      check("t5_out", {out_0, out_1}, {32'(2 * i), 32'(i)});
    end
    set_in(0, 0, 0, 0);
    tick();
    check("t5_done", 64'(done), 64'd1);

    // 6: 200 entries with the consumer ready about half the time
    start = 1'b1; tick(); start = 1'b0;
    idx = 0;
    set_in(1, 1000, 5000, 0);
    for (cyc = 0; cyc < 3000 && (idx < 200 || q.size() != 0); cyc++) begin
      ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      set_in(idx < 200, 1000 + idx, 5000 - 3 * idx, 0);
    end
    check("t6_all_pushed", 64'(idx), 64'd200);
    check("t6_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
